dll_tx_sched: RTL and testbench

Data Link Layer transmit scheduler for the PCIe RC/EP link. It shares the single 32-byte-per-cycle PIPE transmit path between three requesters: the TLP stream from the replay/framing logic, Ack/Nak DLLPs, and UpdateFC DLLPs. It runs the Ack-latency timer and the UpdateFC refresh timer. It emits one tagged beat per cycle to the downstream framer, which inserts the DLLP CRC16 and framing tokens.

---
 rtl/dll_tx_sched_if.sv | 10 +
 rtl/dll_tx_sched.sv | 95 +++++++++
 tb/tb_dll_tx_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/dll_tx_sched_if.sv
// dll_tx_sched_if: TLP beat handshake from the replay/framing logic into the DLL transmit scheduler.
interface dll_tx_sched_if #(parameter int W = 256);
    logic         tlp_valid_i;
    logic         tlp_sop_i;
    logic         tlp_eop_i;
    logic [W-1:0] tlp_data_i;
    logic         tlp_ready_o;
    modport master (output tlp_valid_i, tlp_sop_i, tlp_eop_i, tlp_data_i, input tlp_ready_o);
    modport slave  (input tlp_valid_i, tlp_sop_i, tlp_eop_i, tlp_data_i, output tlp_ready_o);
endinterface

// File: rtl/dll_tx_sched.sv
// dll_tx_sched: shares the PIPE transmit path between TLP beats, Ack/Nak and UpdateFC DLLPs.
module dll_tx_sched #(
    parameter int PIPE_DATA_WIDTH = 256,
    parameter int ACK_TIMER_LIMIT = 64,
    parameter int FC_TIMER_LIMIT  = 256
) (
    input  logic                       sclk,
    input  logic                       sreset,
    input  logic                       tx_en_i,
    dll_tx_sched_if.slave              tlp,
    input  logic                       ack_set_i,
    input  logic                       nak_req_i,
    input  logic [11:0]                ackd_seq_i,
    input  logic [2:0]                 fc_req_i,
    input  logic [7:0]                 fc_hdr_p_i,
    input  logic [7:0]                 fc_hdr_np_i,
    input  logic [7:0]                 fc_hdr_cpl_i,
    input  logic [11:0]                fc_data_p_i,
    input  logic [11:0]                fc_data_np_i,
    input  logic [11:0]                fc_data_cpl_i,
    output logic [PIPE_DATA_WIDTH-1:0] pipe_data_o,
    output logic [1:0]                 pipe_kind_o,
    output logic [15:0]                ack_cnt_o,
    output logic [15:0]                nak_cnt_o
);
    localparam int AW = $clog2(ACK_TIMER_LIMIT + 1);
    localparam int FW = $clog2(FC_TIMER_LIMIT);
    localparam logic [AW-1:0] ACK_MAX = AW'(ACK_TIMER_LIMIT);
    localparam logic [FW-1:0] FC_MAX  = FW'(FC_TIMER_LIMIT - 1);
    typedef enum logic {S_IDLE, S_TLP} state_t;
    localparam logic [1:0] K_IDLE = 2'd0, K_TLP = 2'd1, K_DLLP = 2'd2;
    state_t                     state, state_nx;
    logic                       nak_pend, ack_pend, ack_urgent, arb, urgent_ack;
    logic                       g_nak, g_ack, g_fc, g_tlp, accept, fc_wrap, unused_sop;
    logic [2:0]                 fc_pend, fc_sel;
    logic [AW-1:0]              ack_tmr;
    logic [FW-1:0]              fc_tmr;
    logic [7:0]                 fc_hdr, dllp_type;
    logic [11:0]                fc_data;
    logic [23:0]                body;
    logic [1:0]                 beat_kind;
    logic [PIPE_DATA_WIDTH-1:0] beat;
    assign unused_sop = tlp.tlp_sop_i;
    assign ack_urgent = ack_tmr == ACK_MAX;
    assign fc_wrap    = tx_en_i && fc_tmr == FC_MAX;
    always_ff @(posedge sclk)
        state <= sreset ? S_IDLE : state_nx;
    always_comb
        state_nx = accept ? (tlp.tlp_eop_i ? S_IDLE : S_TLP) : state;
    // One grant per cycle; DLLPs only compete at a packet boundary.
    always_comb begin
        arb             = tx_en_i && state == S_IDLE;
        g_nak           = arb && nak_pend;
        urgent_ack      = arb && !nak_pend && ack_pend && ack_urgent;
        g_fc            = arb && !nak_pend && !urgent_ack && |fc_pend;
        g_tlp           = arb && !nak_pend && !urgent_ack && !(|fc_pend) && tlp.tlp_valid_i;
        g_ack           = urgent_ack || (arb && !nak_pend && !(|fc_pend) && !tlp.tlp_valid_i && ack_pend);
        tlp.tlp_ready_o = state == S_TLP ? tx_en_i : g_tlp;
        accept          = tlp.tlp_valid_i && tlp.tlp_ready_o;
        fc_sel          = g_fc ? fc_pend & (~fc_pend + 3'd1) : 3'd0;
        fc_hdr          = fc_sel[0] ? fc_hdr_p_i : fc_sel[1] ? fc_hdr_np_i : fc_hdr_cpl_i;
        fc_data         = fc_sel[0] ? fc_data_p_i : fc_sel[1] ? fc_data_np_i : fc_data_cpl_i;
        dllp_type       = g_nak ? 8'h10 : g_ack ? 8'h00 : {2'b10, fc_sel[2], fc_sel[1], 4'h0};
        body            = (g_nak || g_ack) ? {12'h0, ackd_seq_i} : {2'b00, fc_hdr, 2'b00, fc_data};
        beat_kind       = accept ? K_TLP : (g_nak || g_ack || g_fc) ? K_DLLP : K_IDLE;
        beat            = accept ? tlp.tlp_data_i :
                          beat_kind == K_DLLP ? {{(PIPE_DATA_WIDTH-32){1'b0}}, body[7:0], body[15:8], body[23:16], dllp_type} :
                          '0;
    end
    // A set request in the same cycle as the clearing issue keeps the flag set.
    always_ff @(posedge sclk) begin
        if (sreset) begin
            pipe_data_o <= '0;
            pipe_kind_o <= K_IDLE;
            ack_cnt_o   <= '0;
            nak_cnt_o   <= '0;
            nak_pend    <= 1'b0;
            ack_pend    <= 1'b0;
            fc_pend     <= '0;
            ack_tmr     <= '0;
            fc_tmr      <= '0;
        end else begin
            pipe_data_o <= beat;
            pipe_kind_o <= beat_kind;
            ack_cnt_o   <= ack_cnt_o + {15'd0, g_ack};
            nak_cnt_o   <= nak_cnt_o + {15'd0, g_nak};
            nak_pend    <= nak_req_i || (nak_pend && !g_nak);
            ack_pend    <= ack_set_i || (ack_pend && !g_ack && !g_nak);
            fc_pend     <= fc_req_i | {3{fc_wrap}} | (fc_pend & ~fc_sel);
            ack_tmr     <= (g_ack || g_nak) ? '0 :
                           (ack_pend && tx_en_i && !ack_urgent) ? ack_tmr + 1'b1 : ack_tmr;
            fc_tmr      <= !tx_en_i ? fc_tmr : fc_wrap ? '0 : fc_tmr + 1'b1;
        end
    end
endmodule

// File: tb/tb_dll_tx_sched.sv
// tb_dll_tx_sched: directed and random stimulus checked against a behavioural scheduler model.
module tb_dll_tx_sched;
    localparam int W = 256, AL = 64, FL = 256;
    logic         sclk = 1'b0, sreset = 1'b1, tx_en = 1'b0, ack_set = 1'b0, nak_req = 1'b0;
    logic [11:0]  seq = '0;
    logic [2:0]   fc_req = '0;
    logic [7:0]   hdr [3];
    logic [11:0]  dat [3];
    logic [W-1:0] pipe_data, b3;
    logic [1:0]   pipe_kind;
    logic [15:0]  ack_cnt, nak_cnt;
    int           checks = 0, errors = 0, n;
    bit           m_tlp, m_nak, m_ack;
    bit   [2:0]   m_fc;
    int           m_at, m_ft, m_kind, m_ackc, m_nakc;
    logic [W-1:0] m_data;

    dll_tx_sched_if #(.W(W)) tlp_if ();

    dll_tx_sched #(.PIPE_DATA_WIDTH(W), .ACK_TIMER_LIMIT(AL), .FC_TIMER_LIMIT(FL)) dut (
        .sclk(sclk), .sreset(sreset), .tx_en_i(tx_en), .tlp(tlp_if),
        .ack_set_i(ack_set), .nak_req_i(nak_req), .ackd_seq_i(seq), .fc_req_i(fc_req),
        .fc_hdr_p_i(hdr[0]), .fc_hdr_np_i(hdr[1]), .fc_hdr_cpl_i(hdr[2]),
        .fc_data_p_i(dat[0]), .fc_data_np_i(dat[1]), .fc_data_cpl_i(dat[2]),
        .pipe_data_o(pipe_data), .pipe_kind_o(pipe_kind), .ack_cnt_o(ack_cnt), .nak_cnt_o(nak_cnt)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] dllp(input int t, input int b1, input int b2, input int b3);
        logic [W-1:0] r;
        r = '0;
        r[7:0]   = 8'(t);
        r[15:8]  = 8'(b1);
        r[23:16] = 8'(b2);
        r[31:24] = 8'(b3);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] r;
        for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Grant codes: 0 idle, 1 TLP, 2 Nak, 3 Ack, 4 UpdateFC.
    task automatic cycle();
        int g, fi, h, d;
        bit wrap;
        #1;
        g = 0;
        fi = 0;
        if (!sreset && tx_en) begin
            if (m_tlp) g = tlp_if.tlp_valid_i ? 1 : 0;
            else if (m_nak) g = 2;
            else if (m_ack && m_at == AL) g = 3;
            else if (m_fc != 0) begin
                g = 4;
                while (!m_fc[fi]) fi++;
            end
            else if (tlp_if.tlp_valid_i) g = 1;
            else if (m_ack) g = 3;
        end
        if (!sreset) check("tlp_ready", tlp_if.tlp_ready_o, tx_en && (m_tlp || g == 1));
        if (sreset) begin
            {m_tlp, m_nak, m_ack, m_fc} = '0;
            m_at = 0; m_ft = 0; m_kind = 0; m_ackc = 0; m_nakc = 0; m_data = '0;
        end else begin
            m_kind = g == 1 ? 1 : g >= 2 ? 2 : 0;
            m_data = '0;
            case (g)
                1: begin m_data = tlp_if.tlp_data_i; m_tlp = !tlp_if.tlp_eop_i; end
                2: begin
                    m_data = dllp(8'h10, 0, int'(seq) / 256, int'(seq) % 256);
                    m_nakc = (m_nakc + 1) % 65536; m_nak = 0; m_ack = 0; m_at = 0;
                end
                3: begin
                    m_data = dllp(8'h00, 0, int'(seq) / 256, int'(seq) % 256);
                    m_ackc = (m_ackc + 1) % 65536; m_ack = 0; m_at = 0;
                end
                4: begin
                    h = int'(hdr[fi]);
                    d = int'(dat[fi]);
                    m_data = dllp(8'h80 + 16 * fi, h / 4, (h % 4) * 64 + d / 256, d % 256);
                    m_fc[fi] = 1'b0;
                end
                default: ;
            endcase
            if (g != 2 && g != 3 && m_ack && tx_en && m_at < AL) m_at++;
            wrap = 1'b0;
            if (tx_en) begin
                if (m_ft == FL - 1) begin m_ft = 0; wrap = 1'b1; end
                else m_ft++;
            end
            m_nak = m_nak | nak_req;
            m_ack = m_ack | ack_set;
            m_fc  = m_fc | fc_req | {3{wrap}};
        end
        @(posedge sclk);
        #1;
        check("pipe_kind", pipe_kind, m_kind);
        check("pipe_data", pipe_data, m_data);
        check("ack_cnt", ack_cnt, m_ackc);
        check("nak_cnt", nak_cnt, m_nakc);
        @(negedge sclk);
    endtask

    initial begin
        tlp_if.tlp_valid_i = 1'b0;
        tlp_if.tlp_sop_i   = 1'b0;
        tlp_if.tlp_eop_i   = 1'b0;
        tlp_if.tlp_data_i  = '0;
        for (int k = 0; k < 3; k++) begin hdr[k] = 8'(k + 1); dat[k] = 12'(k + 16); end
        repeat (3) cycle();
        check("reset_kind", pipe_kind, 0);
        check("reset_data", pipe_data, 0);
        sreset = 1'b0;
        cycle();
        check("reset_ready", tlp_if.tlp_ready_o, 0);

        tx_en = 1'b1;
        seq = 12'h001;
        for (int i = 0; i < 5; i++) begin
            tlp_if.tlp_valid_i = 1'b1;
            tlp_if.tlp_sop_i   = i == 0;
            tlp_if.tlp_eop_i   = i == 4;
            tlp_if.tlp_data_i  = rand_beat();
            nak_req = i == 2;
            cycle();
            check("tlp_contig", pipe_kind, 1);
        end
        tlp_if.tlp_valid_i = 1'b0;
        nak_req = 1'b0;
        cycle();
        check("nak_after_tlp", pipe_data[31:0], 32'h0100_0010);
        check("nak_cnt_one", nak_cnt, 1);

        seq = 12'h005;
        tlp_if.tlp_valid_i = 1'b1;
        tlp_if.tlp_sop_i   = 1'b1;
        tlp_if.tlp_eop_i   = 1'b1;
        tlp_if.tlp_data_i  = rand_beat();
        ack_set = 1'b1;
        cycle();
        ack_set = 1'b0;
        n = -1;
        for (int k = 1; k <= 100 && n < 0; k++) begin
            tlp_if.tlp_data_i = rand_beat();
            cycle();
            if (pipe_kind == 2) n = k;
        end
        check("ack_latency", n, 65);
        check("ack_beat", pipe_data[31:0], 32'h0500_0000);
        check("ack_cnt_one", ack_cnt, 1);

        tlp_if.tlp_valid_i = 1'b0;
        seq = 12'h003;
        ack_set = 1'b1;
        nak_req = 1'b1;
        cycle();
        ack_set = 1'b0;
        nak_req = 1'b0;
        cycle();
        check("nak_absorb", pipe_data[31:0], 32'h0300_0010);
        check("nak_absorb_acks", ack_cnt, 1);
        cycle();
        check("no_ack_after_nak", pipe_kind, 0);

        hdr[0] = 8'h25;
        dat[0] = 12'h1F4;
        n = -1;
        for (int k = 0; k < 300 && n < 0; k++) begin
            cycle();
            if (pipe_kind == 2) n = k;
        end
        check("fc_p", pipe_data[31:0], 32'hF441_0980);
        cycle();
        check("fc_np", {pipe_kind, pipe_data[7:0]}, 10'h290);
        cycle();
        check("fc_cpl", {pipe_kind, pipe_data[7:0]}, 10'h2A0);

        for (int i = 0; i < 3; i++) begin
            tlp_if.tlp_valid_i = 1'b1;
            tlp_if.tlp_sop_i   = i == 0;
            tlp_if.tlp_eop_i   = 1'b0;
            tlp_if.tlp_data_i  = rand_beat();
            cycle();
        end
        b3 = rand_beat();
        tlp_if.tlp_sop_i  = 1'b0;
        tlp_if.tlp_data_i = b3;
        tx_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            nak_req = i == 0;
            fc_req  = i == 1 ? 3'b010 : 3'b000;
            cycle();
            check("gap_idle", pipe_kind, 0);
        end
        nak_req = 1'b0;
        fc_req = '0;
        tx_en = 1'b1;
        cycle();
        check("resume_beat", pipe_data, b3);
        for (int i = 4; i < 6; i++) begin
            tlp_if.tlp_eop_i  = i == 5;
            tlp_if.tlp_data_i = rand_beat();
            cycle();
            check("resume_kind", pipe_kind, 1);
        end
        tlp_if.tlp_valid_i = 1'b0;
        repeat (4) cycle();

        for (int i = 0; i < 3000; i++) begin
            sreset = $urandom_range(499) == 0;
            tx_en  = $urandom_range(9) != 0;
            tlp_if.tlp_valid_i = $urandom_range(9) < 6;
            tlp_if.tlp_sop_i   = 1'($urandom);
            tlp_if.tlp_eop_i   = $urandom_range(2) == 0;
            tlp_if.tlp_data_i  = rand_beat();
            ack_set = $urandom_range(19) == 0;
            nak_req = $urandom_range(49) == 0;
            fc_req  = {$urandom_range(19) == 0, $urandom_range(19) == 0, $urandom_range(19) == 0};
            seq     = 12'($urandom);
            if ($urandom_range(49) == 0)
                for (int k = 0; k < 3; k++) begin hdr[k] = 8'($urandom); dat[k] = 12'($urandom); end
            cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
